// File: rtl/engine_rpm_ctrl_pkg.sv
// Shared types, band thresholds and per-gear gain/drop tables for the engine RPM model.
package engine_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_RUN,
    ST_SHIFT,
    ST_CUT
  } state_t;

  typedef enum logic [1:0] {
    STEP_RUN,
    STEP_UP,
    STEP_DOWN,
    STEP_CUT
  } step_mode_t;

  localparam int unsigned BAND_LOW_MAX  = 4000;
  localparam int unsigned BAND_HIGH_MIN = 7000;
  localparam int unsigned TBL_GEARS     = 6;

  // Rows are gears 0..5, columns are low/mid/high bands.
  localparam int unsigned GAIN_TBL [TBL_GEARS][3] = '{
    '{50, 50, 50},
    '{10, 14, 17},
    '{ 4,  8, 12},
    '{ 4,  8, 12},
    '{ 3,  6,  9},
    '{ 2,  4,  6}
  };

  localparam int unsigned DROP_TBL [TBL_GEARS] = '{0, 3390, 3060, 3080, 2800, 2500};

  function automatic int unsigned gear_clamp(input int unsigned gear);
    return (gear >= TBL_GEARS) ? TBL_GEARS - 1 : gear;
  endfunction

endpackage

// File: rtl/engine_rpm_ctrl_rpm_step_calc.sv
// Combinational candidate-RPM calculator: run step, shift drop/rise and cut decay.
module rpm_step_calc
  import engine_pkg::*;
#(
  parameter int unsigned RPM_W    = 14,
  parameter int unsigned GEAR_W   = 3,
  parameter int unsigned IDLE_RPM = 1140,
  parameter int unsigned MAX_RPM  = 11000,
  parameter int unsigned DECAY    = 10
) (
  input  logic [RPM_W-1:0]  rpm,
  input  logic [GEAR_W-1:0] gear,
  input  logic              gas_key,
  input  step_mode_t        mode,
  output logic [RPM_W-1:0]  rpm_next,
  output logic              saturate
);

  localparam logic [RPM_W:0] IDLE_X  = (RPM_W+1)'(IDLE_RPM);
  localparam logic [RPM_W:0] MAX_X   = (RPM_W+1)'(MAX_RPM);
  localparam logic [RPM_W:0] DECAY_X = (RPM_W+1)'(DECAY);
  localparam logic [RPM_W:0] LOW_X   = (RPM_W+1)'(BAND_LOW_MAX);
  localparam logic [RPM_W:0] HIGH_X  = (RPM_W+1)'(BAND_HIGH_MIN);

  logic [RPM_W:0] rpm_x;
  logic [RPM_W:0] gain_x;
  logic [RPM_W:0] drop_x;
  logic [RPM_W:0] res_x;
  logic [2:0]     gidx;
  logic [1:0]     band;

  assign rpm_x = {1'b0, rpm};

  always_comb begin
    gidx = 3'(gear_clamp(32'(gear)));
    if (rpm_x <= LOW_X)      band = 2'd0;
    else if (rpm_x < HIGH_X) band = 2'd1;
    else                     band = 2'd2;
    gain_x   = (RPM_W+1)'(GAIN_TBL[gidx][band]);
    drop_x   = (RPM_W+1)'(DROP_TBL[gidx]);
    res_x    = rpm_x;
    saturate = 1'b0;
    case (mode)
      STEP_RUN: begin
        if (gas_key) begin
          if (rpm_x + gain_x >= MAX_X) begin
            res_x    = MAX_X;
            saturate = 1'b1;
          end else begin
            res_x = rpm_x + gain_x;
          end
        end else if (rpm_x > IDLE_X) begin
          // Compare before subtracting so the decay can never wrap below idle.
          res_x = (rpm_x < IDLE_X + DECAY_X) ? IDLE_X : rpm_x - DECAY_X;
        end else begin
          res_x = '0;
        end
      end
      STEP_UP: begin
        res_x = (rpm_x > drop_x + IDLE_X) ? rpm_x - drop_x : IDLE_X;
      end
      STEP_DOWN: begin
        if (rpm_x + drop_x >= MAX_X) begin
          res_x    = MAX_X;
          saturate = 1'b1;
        end else begin
          res_x = rpm_x + drop_x;
        end
      end
      STEP_CUT: begin
        res_x = (rpm_x < DECAY_X) ? '0 : rpm_x - DECAY_X;
      end
      default: res_x = rpm_x;
    endcase
    rpm_next = res_x[RPM_W-1:0];
  end

endmodule

// File: rtl/engine_rpm_ctrl.sv
// Engine RPM model: state machine, shift timer and registered cockpit outputs.
module engine_rpm_ctrl
  import engine_pkg::*;
#(
  parameter int unsigned RPM_W           = 14,
  parameter int unsigned GEAR_W          = 3,
  parameter int unsigned NUM_GEARS       = 5,
  parameter int unsigned IDLE_RPM        = 1140,
  parameter int unsigned MAX_RPM         = 11000,
  parameter int unsigned LIMIT_HYST      = 300,
  parameter int unsigned DECAY           = 10,
  parameter int unsigned SHIFT_TICKS     = 20,
  parameter int unsigned SHIFT_LIGHT_RPM = 9500
) (
  input  logic              clk100Hz,
  input  logic              rst,
  input  logic [GEAR_W-1:0] gear_in,
  input  logic              gas_key,
  input  logic              reset_status,
  output logic [RPM_W-1:0]  rpm,
  output logic [GEAR_W-1:0] gear_out,
  output logic              limiter,
  output logic              shift_busy,
  output logic              shift_light
);

  localparam int unsigned        CNT_W      = (SHIFT_TICKS > 1) ? $clog2(SHIFT_TICKS) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(SHIFT_TICKS - 1);
  localparam logic [RPM_W-1:0]   IDLE_V     = RPM_W'(IDLE_RPM);
  localparam logic [RPM_W-1:0]   CUT_EXIT_V = RPM_W'(MAX_RPM - LIMIT_HYST);
  localparam logic [RPM_W-1:0]   LIGHT_V    = RPM_W'(SHIFT_LIGHT_RPM);
  localparam logic [GEAR_W-1:0]  TOP_GEAR   = GEAR_W'(NUM_GEARS);

  state_t            state;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic [RPM_W-1:0]  rpm_d;
  logic [GEAR_W-1:0] gear_d;
  logic [GEAR_W-1:0] calc_gear;
  logic [RPM_W-1:0]  calc_rpm;
  logic              calc_sat;
  step_mode_t        mode;
  logic              req_change;
  logic              via_neutral;

  assign req_change  = (gear_in <= TOP_GEAR) && (gear_in != gear_out);
  assign via_neutral = (gear_in == '0) || (gear_out == '0);

  // Upshift drop is looked up by the target gear, downshift rise by the gear being left.
  always_comb begin
    mode      = STEP_RUN;
    calc_gear = gear_out;
    if (state == ST_CUT) begin
      mode = STEP_CUT;
    end else if (req_change && !via_neutral) begin
      if (gear_in > gear_out) begin
        mode      = STEP_UP;
        calc_gear = gear_in;
      end else begin
        mode = STEP_DOWN;
      end
    end
  end

  rpm_step_calc #(
    .RPM_W   (RPM_W),
    .GEAR_W  (GEAR_W),
    .IDLE_RPM(IDLE_RPM),
    .MAX_RPM (MAX_RPM),
    .DECAY   (DECAY)
  ) u_step (
    .rpm     (rpm),
    .gear    (calc_gear),
    .gas_key (gas_key),
    .mode    (mode),
    .rpm_next(calc_rpm),
    .saturate(calc_sat)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rpm_d   = rpm;
    gear_d  = gear_out;
    case (state)
      ST_STOPPED: begin
        rpm_d = '0;
        if (gas_key) begin
          rpm_d   = IDLE_V;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (req_change) begin
          gear_d  = gear_in;
          cnt_d   = CNT_LOAD;
          state_d = ST_SHIFT;
          rpm_d   = via_neutral ? rpm : calc_rpm;
        end else begin
          rpm_d = calc_rpm;
          if (!gas_key && rpm <= IDLE_V) state_d = ST_STOPPED;
          else if (gas_key && calc_sat)  state_d = ST_CUT;
        end
      end
      ST_SHIFT: begin
        if (cnt == '0) state_d = ST_RUN;
        else           cnt_d   = cnt - 1'b1;
      end
      ST_CUT: begin
        rpm_d = calc_rpm;
        if (calc_rpm <= CUT_EXIT_V) state_d = ST_RUN;
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  always_ff @(posedge clk100Hz) begin
    if (rst || reset_status) begin
      state       <= ST_STOPPED;
      cnt         <= '0;
      rpm         <= '0;
      gear_out    <= '0;
      limiter     <= 1'b0;
      shift_busy  <= 1'b0;
      shift_light <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      rpm         <= rpm_d;
      gear_out    <= gear_d;
      limiter     <= (state_d == ST_CUT);
      shift_busy  <= (state_d == ST_SHIFT);
      shift_light <= (rpm_d >= LIGHT_V);
    end
  end

endmodule

// File: tb/tb_engine_rpm_ctrl.sv
// Scoreboard bench for engine_rpm_ctrl: behavioural model predicts every tick's outputs.
module tb_engine_rpm_ctrl;

  logic        clk100Hz = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  gear_in = '0;
  logic        gas_key = 1'b0;
  logic        reset_status = 1'b0;
  logic [13:0] rpm;
  logic [2:0]  gear_out;
  logic        limiter;
  logic        shift_busy;
  logic        shift_light;

  always #5 clk100Hz = ~clk100Hz;

  engine_rpm_ctrl #(
    .RPM_W(14), .GEAR_W(3), .NUM_GEARS(5), .IDLE_RPM(1140), .MAX_RPM(11000),
    .LIMIT_HYST(300), .DECAY(10), .SHIFT_TICKS(20), .SHIFT_LIGHT_RPM(9500)
  ) dut (
    .clk100Hz    (clk100Hz),
    .rst         (rst),
    .gear_in     (gear_in),
    .gas_key     (gas_key),
    .reset_status(reset_status),
    .rpm         (rpm),
    .gear_out    (gear_out),
    .limiter     (limiter),
    .shift_busy  (shift_busy),
    .shift_light (shift_light)
  );

  typedef struct {
    int rpm;
    int gear;
    int lim;
    int busy;
    int light;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_tick = 0;

  localparam int M_STOP = 0, M_RUN = 1, M_SHIFT = 2, M_CUT = 3;
  int m_state = M_STOP;
  int m_rpm   = 0;
  int m_gear  = 0;
  int m_cnt   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (tick %0d)", tag, got, exp, n_tick);
    end
  endtask

  function automatic int gain_of(input int g, input int r);
    int b;
    b = (r <= 4000) ? 0 : (r < 7000) ? 1 : 2;
    case ((g > 5) ? 5 : g)
      0:       return 50;
      1:       return (b == 0) ? 10 : (b == 1) ? 14 : 17;
      2, 3:    return (b == 0) ? 4 : (b == 1) ? 8 : 12;
      4:       return (b == 0) ? 3 : (b == 1) ? 6 : 9;
      default: return (b == 0) ? 2 : (b == 1) ? 4 : 6;
    endcase
  endfunction

  function automatic int drop_of(input int g);
    case ((g > 5) ? 5 : g)
      1:       return 3390;
      2:       return 3060;
      3:       return 3080;
      4:       return 2800;
      5:       return 2500;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic rs, input logic gas, input int g);
    if (r || rs) begin
      m_state = M_STOP; m_rpm = 0; m_gear = 0; m_cnt = 0;
    end else begin
      case (m_state)
        M_STOP: begin
          m_rpm = 0;
          if (gas) begin m_rpm = 1140; m_state = M_RUN; end
        end
        M_RUN: begin
          if (g <= 5 && g != m_gear) begin
            if (m_gear != 0 && g != 0) begin
              if (g > m_gear)
                m_rpm = (m_rpm > drop_of(g) + 1140) ? m_rpm - drop_of(g) : 1140;
              else
                m_rpm = (m_rpm + drop_of(m_gear) > 11000) ? 11000 : m_rpm + drop_of(m_gear);
            end
            m_gear = g; m_cnt = 19; m_state = M_SHIFT;
          end else if (gas) begin
            m_rpm = m_rpm + gain_of(m_gear, m_rpm);
            if (m_rpm >= 11000) begin m_rpm = 11000; m_state = M_CUT; end
          end else if (m_rpm > 1140) begin
            m_rpm = (m_rpm - 10 < 1140) ? 1140 : m_rpm - 10;
          end else begin
            m_rpm = 0; m_state = M_STOP;
          end
        end
        M_SHIFT: begin
          if (m_cnt == 0) m_state = M_RUN;
          else m_cnt--;
        end
        default: begin
          m_rpm -= 10;
          if (m_rpm <= 10700) m_state = M_RUN;
        end
      endcase
    end
  endtask

  task automatic tick(input logic r, input logic rs, input logic gas, input logic [2:0] g);
    exp_t e;
    rst = r; reset_status = rs; gas_key = gas; gear_in = g;
    model_step(r, rs, gas, int'(g));
    e.rpm = m_rpm; e.gear = m_gear;
    e.lim = (m_state == M_CUT) ? 1 : 0;
    e.busy = (m_state == M_SHIFT) ? 1 : 0;
    e.light = (m_rpm >= 9500) ? 1 : 0;
    sb.push_back(e);
    @(posedge clk100Hz);
    #1;
    n_tick++;
    e = sb.pop_front();
    check("rpm", int'(rpm), e.rpm);
    check("gear_out", int'(gear_out), e.gear);
    check("limiter", int'(limiter), e.lim);
    check("shift_busy", int'(shift_busy), e.busy);
    check("shift_light", int'(shift_light), e.light);
  endtask

  task automatic wait_shift(input logic [2:0] g);
    for (int i = 0; i < 100 && m_state == M_SHIFT; i++) tick(1'b0, 1'b0, 1'b1, g);
  endtask

  task automatic climb_to(input int target, input logic [2:0] g);
    for (int i = 0; i < 2000 && m_rpm < target; i++) tick(1'b0, 1'b0, 1'b1, g);
  endtask

  int busy_len;

  initial begin
    #2;
    tick(1'b1, 1'b0, 1'b0, 3'd0);
    check("reset_rpm", int'(rpm), 0);

    // Neutral climb into the limiter
    tick(1'b0, 1'b0, 1'b1, 3'd0);
    check("idle_start", int'(rpm), 1140);
    tick(1'b0, 1'b0, 1'b1, 3'd0);
    check("neutral_gain", int'(rpm), 1190);
    for (int i = 0; i < 400 && m_state != M_CUT; i++) tick(1'b0, 1'b0, 1'b1, 3'd0);
    check("limit_rpm", int'(rpm), 11000);
    check("limit_on", int'(limiter), 1);

    // Fuel cut with gas held, hysteresis release
    for (int i = 0; i < 100 && m_state == M_CUT; i++) tick(1'b0, 1'b0, 1'b1, 3'd0);
    check("cut_exit_rpm", int'(rpm), 10700);
    check("cut_exit_lim", int'(limiter), 0);
    tick(1'b0, 1'b0, 1'b1, 3'd0);
    check("post_cut", int'(rpm), 10750);

    // Race restart, invalid gear request ignored
    tick(1'b0, 1'b1, 1'b1, 3'd0);
    check("restart_rpm", int'(rpm), 0);
    tick(1'b0, 1'b0, 1'b1, 3'd7);
    tick(1'b0, 1'b0, 1'b1, 3'd7);
    check("invalid_gear", int'(gear_out), 0);

    // Gear 1 to 4000, upshift to floor, then stall
    tick(1'b0, 1'b0, 1'b1, 3'd1);
    wait_shift(3'd1);
    climb_to(4000, 3'd1);
    check("g1_4000", int'(rpm), 4000);
    tick(1'b0, 1'b0, 1'b1, 3'd2);
    check("up_floor", int'(rpm), 1140);
    wait_shift(3'd2);
    tick(1'b0, 1'b0, 1'b0, 3'd2);
    check("stall_rpm", int'(rpm), 0);
    check("stall_gear", int'(gear_out), 2);

    // Downshift rise, neutral climb to 6000, upshift 1->2
    tick(1'b0, 1'b0, 1'b1, 3'd2);
    tick(1'b0, 1'b0, 1'b1, 3'd1);
    check("down_rise", int'(rpm), 4200);
    wait_shift(3'd1);
    tick(1'b0, 1'b0, 1'b1, 3'd0);
    wait_shift(3'd0);
    climb_to(6000, 3'd0);
    tick(1'b0, 1'b0, 1'b1, 3'd1);
    check("into_g1", int'(rpm), 6000);
    wait_shift(3'd1);
    tick(1'b0, 1'b0, 1'b1, 3'd2);
    check("up_drop", int'(rpm), 2940);
    busy_len = int'(shift_busy);
    for (int i = 0; i < 100 && m_state == M_SHIFT; i++) begin
      tick(1'b0, 1'b0, 1'b1, 3'd2);
      busy_len += int'(shift_busy);
    end
    check("busy_len", busy_len, 20);
    tick(1'b0, 1'b0, 1'b1, 3'd2);
    check("after_shift", int'(rpm), 2944);

    // Gear 3 at 9000, saturating downshift, restart mid-shift
    tick(1'b0, 1'b1, 1'b0, 3'd0);
    tick(1'b0, 1'b0, 1'b1, 3'd0);
    tick(1'b0, 1'b0, 1'b1, 3'd2);
    wait_shift(3'd2);
    tick(1'b0, 1'b0, 1'b1, 3'd1);
    wait_shift(3'd1);
    tick(1'b0, 1'b0, 1'b1, 3'd0);
    wait_shift(3'd0);
    climb_to(9000, 3'd0);
    tick(1'b0, 1'b0, 1'b1, 3'd3);
    check("into_g3", int'(rpm), 9000);
    wait_shift(3'd3);
    tick(1'b0, 1'b0, 1'b1, 3'd2);
    check("down_sat", int'(rpm), 11000);
    check("light_on", int'(shift_light), 1);
    repeat (4) tick(1'b0, 1'b0, 1'b1, 3'd2);
    tick(1'b0, 1'b1, 1'b1, 3'd2);
    check("abort_rpm", int'(rpm), 0);
    check("abort_gear", int'(gear_out), 0);
    check("abort_busy", int'(shift_busy), 0);
    repeat (3) tick(1'b0, 1'b0, 1'b1, 3'd7);
    check("invalid_hold", int'(gear_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/engine_rpm_ctrl.md
# engine_rpm_ctrl

Parametrised engine-speed model for the drag-racing game, successor to the fixed 4-gear RPM block. Each `clk100Hz` tick it advances engine RPM from the throttle and the selected gear, using per-gear, per-band gain tables. Relative to its predecessor it adds:
- a gear-count parameter;
- timed gear changes (`shift_busy`);
- rev-limiter fuel cut with hysteresis;
- downshift RPM rise;
- a shift-light output.

Outputs feed the cockpit display, the tachometer, and the car-speed block.

## Interface
- `RPM_W`, 14: RPM register width.
- `GEAR_W`, 3: gear code width; 0 is neutral.
- `NUM_GEARS`, 5: highest valid gear code. Requires `NUM_GEARS` < 2^`GEAR_W`.
- `IDLE_RPM`, 1140: idle speed and post-shift floor.
- `MAX_RPM`, 11000: limiter threshold and saturation ceiling.
- `LIMIT_HYST`, 300: fuel cut releases at `MAX_RPM`−`LIMIT_HYST`.
- `DECAY`, 10: RPM lost per tick off-throttle or in cut.
- `SHIFT_TICKS`, 20: duration of a gear change, in ticks.
- `SHIFT_LIGHT_RPM`, 9500: shift-light threshold.

Ports:
- `clk100Hz`  in  1  game tick clock. The only clock.
- `rst`  in  1  synchronous, active-high reset.
- `gear_in`  in  `GEAR_W`  requested gear.
- `gas_key`  in  1  throttle held.
- `reset_status`  in  1  race restart. Synchronous clear, lower priority than `rst`.
- `rpm`  out  `RPM_W`  current RPM, registered.
- `gear_out`  out  `GEAR_W`  engaged gear, registered.
- `limiter`  out  1  high while in state CUT.
- `shift_busy`  out  1  high while in state SHIFT.
- `shift_light`  out  1  high when `rpm` ≥ `SHIFT_LIGHT_RPM`, registered.

## Operation
States: STOPPED, RUN, SHIFT, CUT.

Priority on each tick: `rst` first, then `reset_status`, then state logic. Both clear all outputs to 0 and force STOPPED.

Gain bands: low is `rpm` ≤ 4000, mid is 4001–6999, high is ≥ 7000. Gain and drop tables:
- Gear 0 (neutral): gain 50 in all bands.
- Gear 1: gain {10,14,17}, drop 3390.
- Gear 2: gain {4,8,12}, drop 3060.
- Gear 3: gain {4,8,12}, drop 3080.
- Gear 4: gain {3,6,9}, drop 2800.
- Gear 5: gain {2,4,6}, drop 2500.
- Gears above 5 reuse the gear-5 entries.

Invalid request: `gear_in` > `NUM_GEARS` is ignored and `gear_out` holds.

**STOPPED:** `rpm` = 0.
- `gas_key` → `rpm` ← `IDLE_RPM`, go to RUN.

**RUN, `gear_in` = `gear_out`:**
- With `gas_key`: `rpm` ← min(`rpm` + gain, `MAX_RPM`). If the result equals `MAX_RPM`, go to CUT.
- Without `gas_key`, `rpm` > `IDLE_RPM`: `rpm` ← max(`rpm` − `DECAY`, `IDLE_RPM`).
- Without `gas_key`, `rpm` ≤ `IDLE_RPM`: stall. `rpm` ← 0, go to STOPPED.

**RUN, valid `gear_in` ≠ `gear_out`:** `gear_out` ← `gear_in`, shift counter ← `SHIFT_TICKS`−1, go to SHIFT. The RPM update depends on the direction:
- Upshift into gear g ≥ 1: if `rpm` > drop[g] + `IDLE_RPM`, then `rpm` ← `rpm` − drop[g]; otherwise `rpm` ← `IDLE_RPM`.
- Downshift from gear g ≥ 1 to a non-zero gear: `rpm` ← min(`rpm` + drop[g], `MAX_RPM`).
- Shift into or out of neutral: `rpm` unchanged.

**SHIFT:** `rpm` is held, and `gas_key` and `gear_in` are ignored. Counter decrements each tick. When the counter reaches 0, go to RUN; a pending mismatch is re-evaluated on the following tick.

**CUT:** `rpm` ← `rpm` − `DECAY` every tick, regardless of `gas_key`. When `rpm` ≤ `MAX_RPM`−`LIMIT_HYST`, go to RUN.

**Arithmetic:** all sums and differences are computed at `RPM_W`+1 bits before saturating. Parameter legality requires `MAX_RPM` + 50 < 2^`RPM_W`.

## Timing
- All outputs are registered. Every input takes effect on the first `clk100Hz` edge after it is sampled: one-tick latency.
- `shift_busy` stays high for exactly `SHIFT_TICKS` ticks, starting on the tick `gear_out` changes.
- `shift_light` is computed from the next-state `rpm`, so it is coherent with `rpm` on the same tick.
- Asserting `reset_status` during SHIFT or CUT aborts the state on the next tick; no residual counter state remains.

## Structure
- `engine_pkg` holds:
  - the state enum;
  - the band thresholds 4000 and 7000;
  - the gain table and drop table, as constant arrays indexed by gear;
  - a `gear_clamp` function.
- Sub-module `rpm_step_calc` is combinational. Inputs: `rpm`, gear, `gas_key`, shift direction. Outputs: the candidate next RPM and the saturate flag.
- The top level holds the FSM, the shift counter and the output registers.

## Test plan
1. `rst`, neutral, `gas_key` held → 1140, 1190, 1240, … on successive ticks; `limiter` = 1 on the tick `rpm` reaches 11000.
2. CUT with `gas_key` held → 10990 down to 10700 over 30 ticks; `limiter` drops on the tick `rpm` = 10700; then 10750.
3. Gear 1 at 6000, `gear_in` = 2 → `rpm` = 2940, `gear_out` = 2, `shift_busy` high for 20 ticks with `rpm` = 2940 despite gas; then 2944.
4. Gear 1 at 4000, upshift to 2 → `rpm` = 1140 (floor). Gear 3 at 9000, downshift to 2 → `rpm` = 11000 (saturated).
5. Gear 2 at 1140, gas released → `rpm` = 0, state STOPPED, `gear_out` stays 2.
6. `reset_status` pulse on the 5th tick of SHIFT → next tick `rpm` = 0, `gear_out` = 0, `shift_busy` = 0. Then `gear_in` = 7 with `NUM_GEARS` = 5 → `gear_out` stays 0.
